// File: rtl/sigma_pkg.sv
// rtl/sigma_pkg.sv - shared frame constants and owner tag type for the sigma scheduler
package sigma_pkg;
  localparam int FRAME_LEN = 16;
  localparam int DATA_W    = 8;
  localparam int SUM_W     = 12;
  localparam int PH_W      = $clog2(FRAME_LEN);
  localparam int CH_MAX_W  = 3;

  typedef struct packed {
    logic                valid;
    logic [CH_MAX_W-1:0] ch;
  } tag_t;
endpackage

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - one-hot round-robin arbiter, evaluated only when i_en is high
module rr_arb #(
  parameter int NCH = 4,
  parameter int CHW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           res,
  input  logic           i_en,
  input  logic [NCH-1:0] i_req,
  output logic [NCH-1:0] o_gnt,
  output logic           o_vld,
  output logic [CHW-1:0] o_idx
);
  logic [CHW-1:0] r_ptr;
  logic [NCH-1:0] r_gnt;
  logic           r_vld;
  logic [CHW-1:0] r_idx;
  logic           w_win_vld;
  logic [CHW-1:0] w_win_idx;

  function automatic logic [CHW-1:0] wrap_inc(input logic [CHW-1:0] a, input int k);
    int s;
    s = int'(a) + k;
    if (s >= NCH) s = s - NCH;
    return CHW'(s);
  endfunction

  // Scan downwards so the requester nearest the pointer is the last, winning, assignment.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = '0;
    for (int k = NCH-1; k >= 0; k--) begin
      if (i_req[wrap_inc(r_ptr, k)]) begin
        w_win_vld = 1'b1;
        w_win_idx = wrap_inc(r_ptr, k);
      end
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_ptr <= '0;
      r_gnt <= '0;
      r_vld <= 1'b0;
      r_idx <= '0;
    end else if (i_en) begin
      r_gnt <= w_win_vld ? (NCH'(1) << w_win_idx) : '0;
      r_vld <= w_win_vld;
      r_idx <= w_win_idx;
      if (w_win_vld) r_ptr <= wrap_inc(w_win_idx, 1);
    end
  end

  assign o_gnt = r_gnt;
  assign o_vld = r_vld;
  assign o_idx = r_idx;
endmodule

// File: rtl/sigma_rr_sched.sv
// rtl/sigma_rr_sched.sv - shares one 16-strobe sigma accumulator among NCH sources, frame by frame
module sigma_rr_sched
  import sigma_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int HALF_PER = 10,
  parameter int CHW      = $clog2(NCH)
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic [NCH-1:0]        req,
  input  logic [NCH*DATA_W-1:0] data_in,
  output logic [NCH-1:0]        gnt,
  output logic                  acc_syn,
  output logic [DATA_W-1:0]     acc_data,
  input  logic [SUM_W-1:0]      acc_result,
  input  logic                  acc_syn_out,
  output logic [SUM_W-1:0]      result_out,
  output logic [CHW-1:0]        result_ch,
  output logic                  result_vld
);
  localparam int              DIV_W   = $clog2(HALF_PER);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(FRAME_LEN-1);

  logic [DIV_W-1:0] r_div;
  logic             r_syn;
  logic [PH_W-1:0]  r_ph;
  tag_t             r_cur_tag;
  tag_t             r_prev_tag;
  logic [SUM_W-1:0] r_result_out;
  logic [CHW-1:0]   r_result_ch;
  logic             r_result_vld;

  logic             w_edge;
  logic             w_rise;
  logic             w_arb;
  logic             w_frame_start;
  logic             w_arb_vld;
  logic [CHW-1:0]   w_arb_idx;
  tag_t             w_arb_tag;
  logic             w_prev_ok;

  assign w_edge        = (r_div == DIV_W'(HALF_PER-1));
  assign w_rise        = w_edge & ~r_syn;
  assign w_arb         = w_edge & r_syn & (r_ph == PH_LAST);
  assign w_frame_start = w_rise & (r_ph == PH_LAST);

  rr_arb #(.NCH(NCH), .CHW(CHW)) u_arb (
    .clk   (clk),
    .res   (res),
    .i_en  (w_arb),
    .i_req (req),
    .o_gnt (gnt),
    .o_vld (w_arb_vld),
    .o_idx (w_arb_idx)
  );

  assign w_arb_tag.valid = w_arb_vld;
  assign w_arb_tag.ch    = CH_MAX_W'(w_arb_idx);
  assign w_prev_ok       = r_prev_tag.valid && (int'(r_prev_tag.ch) < NCH);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_div <= '0;
      r_syn <= 1'b0;
      r_ph  <= '0;
    end else begin
      if (w_edge) begin
        r_div <= '0;
        r_syn <= ~r_syn;
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
      if (w_rise) r_ph <= r_ph + PH_W'(1);
    end
  end

  // The accumulator hands back the finished frame's sum just after the next frame's
  // first strobe, so the owner of the frame that just ended must survive one more frame.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_cur_tag    <= '0;
      r_prev_tag   <= '0;
      r_result_out <= '0;
      r_result_ch  <= '0;
      r_result_vld <= 1'b0;
    end else begin
      if (w_frame_start) begin
        r_prev_tag <= r_cur_tag;
        r_cur_tag  <= w_arb_tag;
      end
      r_result_vld <= acc_syn_out & w_prev_ok;
      if (acc_syn_out && w_prev_ok) begin
        r_result_out <= acc_result;
        r_result_ch  <= r_prev_tag.ch[CHW-1:0];
      end
    end
  end

  always_comb begin
    acc_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt[i]) acc_data = acc_data | data_in[i*DATA_W +: DATA_W];
    end
  end

  assign acc_syn    = r_syn;
  assign result_out = r_result_out;
  assign result_ch  = r_result_ch;
  assign result_vld = r_result_vld;
endmodule

// File: tb/tb_sigma_rr_sched.sv
// tb/tb_sigma_rr_sched.sv - self-checking bench with an accumulator model and a timeline-based scheduler model
module tb_sigma_rr_sched;
  localparam int NCH = 4;
  localparam int CHW = $clog2(NCH);
  localparam int H   = 10;
  localparam int P   = 32 * H;

  logic             clk = 1'b0;
  logic             res = 1'b0;
  logic [NCH-1:0]   req = '0;
  logic [NCH*8-1:0] data_in = '0;
  logic [NCH-1:0]   gnt;
  logic             acc_syn;
  logic [7:0]       acc_data;
  logic [11:0]      acc_result = '0;
  logic             acc_syn_out = 1'b0;
  logic [11:0]      result_out;
  logic [CHW-1:0]   result_ch;
  logic             result_vld;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  sigma_rr_sched #(.NCH(NCH), .HALF_PER(H)) dut (
    .clk         (clk),
    .res         (res),
    .req         (req),
    .data_in     (data_in),
    .gnt         (gnt),
    .acc_syn     (acc_syn),
    .acc_data    (acc_data),
    .acc_result  (acc_result),
    .acc_syn_out (acc_syn_out),
    .result_out  (result_out),
    .result_ch   (result_ch),
    .result_vld  (result_vld)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sx8(input logic [7:0] d);
    return int'($signed(d));
  endfunction

  function automatic logic [7:0] dsel(input int i);
    if (i < 0) return 8'h00;
    return data_in[8*i +: 8];
  endfunction

  // Shared accumulator: sums 16 sign-extended samples, returns the sum on the next frame's first strobe.
  int   acc_ec;
  int   acc_sum;
  logic acc_prev;
  always @(negedge clk) begin
    if (!res) begin
      acc_ec = 0; acc_sum = 0; acc_prev = 1'b0; acc_syn_out = 1'b0; acc_result = '0;
    end else begin
      acc_syn_out = 1'b0;
      if (acc_syn && !acc_prev) begin
        if (acc_ec == 15) begin
          acc_result  = 12'(acc_sum);
          acc_syn_out = 1'b1;
          acc_sum     = sx8(acc_data);
        end else begin
          acc_sum = acc_sum + sx8(acc_data);
        end
        acc_ec = (acc_ec + 1) % 16;
      end
      acc_prev = acc_syn;
    end
  end

  typedef struct {int n; logic [11:0] r; int ch;} ent_t;
  ent_t log_q[$];

  // Scheduler model on the clock count since release: falls at 2kH, rises at (2k+1)H;
  // arbitration at n%P==30H, frame start at n%P==31H, tagged result one clk later.
  int             n_cyc = 0;
  int             mptr, arb_owner, fr_owner, done_owner;
  logic [NCH-1:0] e_gnt;
  logic           e_syn, e_vld;
  logic [7:0]     e_data;
  logic [11:0]    e_res;
  int             e_ch;
  always @(posedge clk) begin
    #1;
    if (!res) begin
      n_cyc = 0; mptr = 0; arb_owner = -1; fr_owner = -1; done_owner = -1;
      e_res = '0; e_ch = 0; e_vld = 1'b0; e_syn = 1'b0;
    end else begin
      n_cyc++;
      e_syn = ((n_cyc / H) % 2) == 1;
      if (n_cyc % P == 30*H) begin
        arb_owner = -1;
        for (int k = 0; k < NCH; k++) begin
          int c;
          c = (mptr + k) % NCH;
          if (arb_owner < 0 && req[c]) arb_owner = c;
        end
        if (arb_owner >= 0) mptr = (arb_owner + 1) % NCH;
      end
      if (n_cyc % P == 31*H) begin
        done_owner = fr_owner;
        fr_owner   = arb_owner;
      end
      e_vld = (n_cyc % P == 31*H + 1) && (done_owner >= 0);
      if (e_vld) begin
        e_res = 12'(16 * sx8(dsel(done_owner)));
        e_ch  = done_owner;
      end
    end
    e_gnt = '0;
    if (res && arb_owner >= 0) e_gnt[arb_owner] = 1'b1;
    e_data = res ? dsel(arb_owner) : 8'h00;
    chk("gnt", gnt, e_gnt);
    chk("acc_syn", acc_syn, e_syn);
    chk("acc_data", acc_data, e_data);
    chk("result_vld", result_vld, e_vld);
    chk("result_out", result_out, e_res);
    chk("result_ch", result_ch, e_ch);
    if (result_vld === 1'b1) log_q.push_back('{n_cyc, result_out, int'(result_ch)});
  end

  task automatic start(input logic [NCH-1:0] rq, input logic [NCH*8-1:0] d);
    @(negedge clk);
    res = 1'b0; req = rq; data_in = d;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_syn", acc_syn, 0);
    chk("rst_data", acc_data, 0);
    chk("rst_vld", result_vld, 0);
    chk("rst_out", result_out, 0);
    chk("rst_ch", result_ch, 0);
    repeat (3) @(negedge clk);
    res = 1'b1;
    log_q.delete();
  endtask

  task automatic to_cycle(input int target);
    for (int i = 0; i < 20000 && n_cyc < target; i++) begin
      @(posedge clk); #2;
    end
    chk("to_cycle", n_cyc, target);
  endtask

  task automatic chk_log(input string name, input int idx, input int en, input logic [11:0] er, input int ech);
    if (log_q.size() <= idx) begin
      n_checks++; n_err++;
      $display("FAIL %s: result %0d missing, got %0d results", name, idx, log_q.size());
    end else begin
      chk({name, "_when"}, log_q[idx].n, en);
      chk({name, "_sum"}, log_q[idx].r, er);
      chk({name, "_ch"}, log_q[idx].ch, ech);
    end
  endtask

  initial begin
    // 1: idle, clock timing only
    start(4'b0000, 32'h0);
    to_cycle(9);   chk("s1_syn9", acc_syn, 0);
    to_cycle(10);  chk("s1_syn10", acc_syn, 1);
    to_cycle(20);  chk("s1_syn20", acc_syn, 0);
    to_cycle(30);  chk("s1_syn30", acc_syn, 1);
    to_cycle(700); chk("s1_nres", log_q.size(), 0);

    // 2: single requester
    start(4'b0100, 32'h01010101);
    to_cycle(305); chk("s2_gnt", gnt, 4'b0100); chk("s2_data", acc_data, 8'h01);
    to_cycle(640); chk("s2_nres", log_q.size(), 1);
    chk_log("s2", 0, 631, 12'h010, 2);

    // 3: all requesting, rotation
    start(4'b1111, 32'h04030201);
    to_cycle(1600); chk("s3_gnt5", gnt, 4'b0001);
    chk("s3_nres", log_q.size(), 4);
    chk_log("s3r0", 0, 631,  12'h010, 0);
    chk_log("s3r1", 1, 951,  12'h020, 1);
    chk_log("s3r2", 2, 1271, 12'h030, 2);
    chk_log("s3r3", 3, 1591, 12'h040, 3);

    // 4: negative sum passes through unchanged
    start(4'b0010, 32'h5555FF55);
    to_cycle(640);
    chk_log("s4", 0, 631, 12'hFF0, 1);

    // 5: req[1] dropped mid-frame at edge 20
    start(4'b1010, 32'h44332211);
    to_cycle(390);
    @(negedge clk); req = 4'b1000;
    to_cycle(700); chk("s5_gnt", gnt, 4'b1000);
    to_cycle(960); chk("s5_nres", log_q.size(), 2);
    chk_log("s5r0", 0, 631, 12'h220, 1);
    chk_log("s5r1", 1, 951, 12'h440, 3);

    // 6: reset at edge 40, mid-frame
    start(4'b0100, 32'h01010101);
    to_cycle(790); chk("s6_edge40", acc_syn, 1); chk("s6_pre_nres", log_q.size(), 1);
    start(4'b0100, 32'h01010101);
    to_cycle(700); chk("s6_nres", log_q.size(), 1);
    chk_log("s6", 0, 631, 12'h010, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
